// File: rtl/btn_event_sched.sv
// btn_event_sched: collects per-channel press/release strobes from debounced
// switches. It arbitrates the pending events round-robin onto one
// valid/ready event port.
//
// Optional feature macro: BTN_EVENT_SCHED_AUTOREPEAT_EN
//   Adds auto-repeat (type 2'b10) events while a key stays pressed.
//   Adds the ports rpt_delay_i and rpt_period_i.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   down_i / up_i       one-cycle press / release strobes, bit k = channel k
//   state_i             debounced level per channel (1 = pressed)
//   rpt_delay_i         cycles from press to first repeat (macro only, 0 = off)
//   rpt_period_i        cycles between repeats (macro only, 0 = off)
//   evt_valid_o/ready_i event handshake
//   evt_id_o/type_o     channel index and event type (00 press, 01 release, 10 repeat)
//   ovf_o / ovf_clr_i   sticky lost-event flag and its clear
//   busy_o              any event pending or presented (combinational)
module btn_event_sched #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned ID_WIDTH  = 2,
    parameter int unsigned RPT_WIDTH = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N_CH-1:0]      down_i,
    input  logic [N_CH-1:0]      up_i,
    input  logic [N_CH-1:0]      state_i,
`ifdef BTN_EVENT_SCHED_AUTOREPEAT_EN
    input  logic [RPT_WIDTH-1:0] rpt_delay_i,
    input  logic [RPT_WIDTH-1:0] rpt_period_i,
`endif
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [ID_WIDTH-1:0]  evt_id_o,
    output logic [1:0]           evt_type_o,
    output logic                 ovf_o,
    input  logic                 ovf_clr_i,
    output logic                 busy_o
);

    localparam int unsigned N_IDX       = 1 << ID_WIDTH;
    localparam logic [1:0]  TYPE_PRESS  = 2'b00;
    localparam logic [1:0]  TYPE_RELEASE = 2'b01;
    localparam logic [1:0]  TYPE_REPEAT = 2'b10;

    // Elaboration-time parameter sanity check
    if (N_CH < 2 || N_CH > 16 || N_IDX < N_CH || RPT_WIDTH < 1) begin : g_bad_param
        $error("btn_event_sched: illegal parameter combination");
    end

    logic [N_CH-1:0]     pd_dn, pd_up, pd_rp;
    logic [N_CH-1:0]     pd_dn_n, pd_up_n, pd_rp_n;
    logic [N_CH-1:0]     clr_dn, clr_up, clr_rp;
    logic [N_CH-1:0]     rp_set, rp_stop;
    logic [N_IDX-1:0]    any_pd;
    logic [ID_WIDTH-1:0] rr_ptr, rr_next, gnt_idx, cand;
    logic [1:0]          gnt_type;
    logic                gnt_found;
    logic                load;
    logic                ovf_set;
    int unsigned         idx_sum;

    // Output register may take a new event when empty or being consumed now
    assign load = ~evt_valid_o | evt_ready_i;

    // Release or a dropped level ends any repeat activity on that channel
    assign rp_stop = up_i | ~state_i;

`ifdef BTN_EVENT_SCHED_AUTOREPEAT_EN
    // Per-channel repeat down-counter, armed by a press
    logic                 rpt_en;
    logic [N_CH-1:0]      rpt_act;
    logic [RPT_WIDTH-1:0] rpt_cnt [N_CH];

    assign rpt_en = (rpt_delay_i != '0) && (rpt_period_i != '0);

    always_comb begin
        rp_set = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            rp_set[k] = rpt_act[k] & rpt_en & ~down_i[k] & ~rp_stop[k]
                        & (rpt_cnt[k] == RPT_WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rpt_act <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                rpt_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (down_i[k]) begin
                    rpt_act[k] <= rpt_en;
                    rpt_cnt[k] <= rpt_delay_i;
                end else if (rp_stop[k] || !rpt_en) begin
                    rpt_act[k] <= 1'b0;
                end else if (rpt_act[k]) begin
                    // Expiry reloads with the period for the next repeat
                    rpt_cnt[k] <= (rpt_cnt[k] == RPT_WIDTH'(1)) ? rpt_period_i
                                                                : rpt_cnt[k] - RPT_WIDTH'(1);
                end
            end
        end
    end
`else
    assign rp_set = '0;
`endif

    // Channel request vector, padded so any ID_WIDTH index is legal
    always_comb begin
        any_pd = '0;
        any_pd[N_CH-1:0] = pd_dn | pd_up | pd_rp;
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr;
        cand      = '0;
        idx_sum   = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx_sum = 32'(rr_ptr) + i;
            if (idx_sum >= N_CH) begin
                idx_sum = idx_sum - N_CH;
            end
            cand = ID_WIDTH'(idx_sum);
            if (!gnt_found && any_pd[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign rr_next = (gnt_idx == ID_WIDTH'(N_CH - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);

    // Pick one event of the granted channel: press > release > repeat
    always_comb begin
        gnt_type = TYPE_PRESS;
        clr_dn   = '0;
        clr_up   = '0;
        clr_rp   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (load && gnt_found && gnt_idx == ID_WIDTH'(k)) begin
                if (pd_dn[k]) begin
                    gnt_type  = TYPE_PRESS;
                    clr_dn[k] = 1'b1;
                end else if (pd_up[k]) begin
                    gnt_type  = TYPE_RELEASE;
                    clr_up[k] = 1'b1;
                end else begin
                    gnt_type  = TYPE_REPEAT;
                    clr_rp[k] = 1'b1;
                end
            end
        end
    end

    // A new strobe beats a same-cycle clear; a strobe on a still-held bit is lost
    always_comb begin
        pd_dn_n = (pd_dn & ~clr_dn) | down_i;
        pd_up_n = (pd_up & ~clr_up) | up_i;
        pd_rp_n = ((pd_rp & ~clr_rp) | rp_set) & ~rp_stop;
        ovf_set = (|(down_i & pd_dn & ~clr_dn))
                | (|(up_i   & pd_up & ~clr_up))
                | (|(rp_set & pd_rp & ~clr_rp));
    end

    // Pending store, arbitration pointer, output register and overflow flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pd_dn       <= '0;
            pd_up       <= '0;
            pd_rp       <= '0;
            rr_ptr      <= '0;
            evt_valid_o <= 1'b0;
            evt_id_o    <= '0;
            evt_type_o  <= 2'b00;
            ovf_o       <= 1'b0;
        end else begin
            pd_dn <= pd_dn_n;
            pd_up <= pd_up_n;
            pd_rp <= pd_rp_n;
            ovf_o <= ovf_set | (ovf_o & ~ovf_clr_i);
            if (load) begin
                evt_valid_o <= gnt_found;
                if (gnt_found) begin
                    evt_id_o   <= gnt_idx;
                    evt_type_o <= gnt_type;
                    rr_ptr     <= rr_next;
                end
            end
        end
    end

    assign busy_o = (|pd_dn) | (|pd_up) | (|pd_rp) | evt_valid_o;

endmodule

// File: tb/tb_btn_event_sched.sv
// Scoreboard bench for btn_event_sched. A transaction-level reference model
// pushes expected events. A monitor compares each presented event and pops it
// on handshake. Directed scenarios plus randomized strobes/backpressure.
module tb_btn_event_sched;

    localparam int N_CH      = 4;
    localparam int ID_WIDTH  = 2;
    localparam int RPT_WIDTH = 20;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_CH-1:0]     down, up, state;
    logic                ready, ovf_clr;
    logic                evt_valid;
    logic [ID_WIDTH-1:0] evt_id;
    logic [1:0]          evt_type;
    logic                ovf, busy;
`ifdef BTN_EVENT_SCHED_AUTOREPEAT_EN
    logic [RPT_WIDTH-1:0] rpt_delay  = '0;
    logic [RPT_WIDTH-1:0] rpt_period = '0;
`endif

    always #5 clk = ~clk;

    btn_event_sched #(.N_CH(N_CH), .ID_WIDTH(ID_WIDTH), .RPT_WIDTH(RPT_WIDTH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .down_i      (down),
        .up_i        (up),
        .state_i     (state),
`ifdef BTN_EVENT_SCHED_AUTOREPEAT_EN
        .rpt_delay_i (rpt_delay),
        .rpt_period_i(rpt_period),
`endif
        .evt_valid_o (evt_valid),
        .evt_ready_i (ready),
        .evt_id_o    (evt_id),
        .evt_type_o  (evt_type),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
        .busy_o      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int id;
        int typ;
    } evt_t;

    evt_t exp_q[$];
    int   log_q[$];

    // Reference model state: pending sets, rotating start channel, port status
    bit m_dn[N_CH];
    bit m_up[N_CH];
    bit m_valid, m_ovf, m_lost;
    int m_rr, m_pick, m_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        bit b = m_valid;
        for (int k = 0; k < N_CH; k++) b = b | m_dn[k] | m_up[k];
        return b;
    endfunction

    // Reference model: one step per clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                m_dn[k] = 1'b0;
                m_up[k] = 1'b0;
            end
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_rr    = 0;
            exp_q.delete();
        end else begin
            if (!m_valid || ready) begin
                m_pick = -1;
                for (int i = 0; i < N_CH; i++) begin
                    m_c = (m_rr + i) % N_CH;
                    if (m_pick < 0 && (m_dn[m_c] || m_up[m_c])) m_pick = m_c;
                end
                if (m_pick >= 0) begin
                    if (m_dn[m_pick]) begin
                        exp_q.push_back('{id: m_pick, typ: 0});
                        m_dn[m_pick] = 1'b0;
                    end else begin
                        exp_q.push_back('{id: m_pick, typ: 1});
                        m_up[m_pick] = 1'b0;
                    end
                    m_rr    = (m_pick + 1) % N_CH;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_lost = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                if (down[k]) begin
                    if (m_dn[k]) m_lost = 1'b1;
                    m_dn[k] = 1'b1;
                end
                if (up[k]) begin
                    if (m_up[k]) m_lost = 1'b1;
                    m_up[k] = 1'b1;
                end
            end
            m_ovf = m_lost || (m_ovf && !ovf_clr);
        end
    end

    // Monitor: compare presented event and status; pop on handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 32'(evt_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ovf", 32'(ovf), 32'd0);
        end else begin
            check("valid", 32'(evt_valid), 32'(m_valid));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("busy", 32'(busy), 32'(m_busy()));
            if (evt_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_evt", 32'(evt_valid), 32'd0);
                end else begin
                    check("evt_id", 32'(evt_id), 32'(exp_q[0].id));
                    check("evt_type", 32'(evt_type), 32'(exp_q[0].typ));
                    if (ready) begin
                        log_q.push_back(int'(evt_id));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_dn(input logic [N_CH-1:0] m);
        down = m;
        tick();
        down = '0;
    endtask

    task automatic pulse_up(input logic [N_CH-1:0] m);
        up = m;
        tick();
        up = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        down    = '0;
        up      = '0;
        state   = '0;
        ready   = 1'b1;
        ovf_clr = 1'b0;
        tick();
        // Reset values
        check("reset_valid", 32'(evt_valid), 32'd0);
        check("reset_id", 32'(evt_id), 32'd0);
        check("reset_type", 32'(evt_type), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Single event: two-edge latency, one-cycle presentation
        pulse_dn(4'b0100);
        check("lat_valid_t1", 32'(evt_valid), 32'd0);
        check("lat_busy_t1", 32'(busy), 32'd1);
        tick();
        check("lat_valid_t2", 32'(evt_valid), 32'd1);
        check("lat_id_t2", 32'(evt_id), 32'd2);
        check("lat_type_t2", 32'(evt_type), 32'd0);
        tick();
        check("lat_valid_t3", 32'(evt_valid), 32'd0);
        check("lat_busy_t3", 32'(busy), 32'd0);

        // Round-robin ordering from a fresh pointer
        do_reset();
        log_q.delete();
        pulse_dn(4'b1111);
        repeat (6) tick();
        check("rr_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) check("rr_order", 32'(log_q[i]), 32'(i));
        log_q.delete();
        pulse_dn(4'b1001);
        repeat (4) tick();
        check("rr2_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("rr2_first", 32'(log_q[0]), 32'd0);
            check("rr2_second", 32'(log_q[1]), 32'd3);
        end

        // Backpressure: press held stable, release follows after ready
        ready = 1'b0;
        log_q.delete();
        pulse_dn(4'b0010);
        tick();
        pulse_up(4'b0010);
        repeat (17) tick();
        check("bp_valid", 32'(evt_valid), 32'd1);
        check("bp_id", 32'(evt_id), 32'd1);
        check("bp_type", 32'(evt_type), 32'd0);
        check("bp_ovf", 32'(ovf), 32'd0);
        ready = 1'b1;
        tick();
        check("bp_rel_valid", 32'(evt_valid), 32'd1);
        check("bp_rel_type", 32'(evt_type), 32'd1);
        tick();
        check("bp_idle", 32'(evt_valid), 32'd0);
        check("bp_count", 32'(log_q.size()), 32'd2);

        // Overflow: second press on a pending channel is lost
        ready = 1'b0;
        log_q.delete();
        pulse_dn(4'b1000);
        tick();
        pulse_dn(4'b0001);
        repeat (4) tick();
        check("ovf_before", 32'(ovf), 32'd0);
        pulse_dn(4'b0001);
        check("ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        ovf_clr = 1'b1;
        down    = 4'b0001;
        tick();
        ovf_clr = 1'b0;
        down    = '0;
        check("ovf_set_wins", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        ready   = 1'b1;
        repeat (4) tick();
        check("ovf_deliv_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("ovf_deliv_0", 32'(log_q[0]), 32'd3);
            check("ovf_deliv_1", 32'(log_q[1]), 32'd0);
        end

        // Reset mid-operation drops presented and pending events
        ready = 1'b0;
        pulse_dn(4'b1111);
        tick();
        check("pre_rst_valid", 32'(evt_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_id", 32'(evt_id), 32'd0);
        check("mid_rst_type", 32'(evt_type), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        log_q.delete();
        ready = 1'b1;
        repeat (5) tick();
        check("post_rst_events", 32'(log_q.size()), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Randomized strobes, levels, backpressure and clears
        repeat (3000) begin
            down    = N_CH'($urandom() & $urandom() & $urandom());
            up      = N_CH'($urandom() & $urandom() & $urandom());
            state   = N_CH'($urandom());
            ready   = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        down    = '0;
        up      = '0;
        ovf_clr = 1'b0;
        ready   = 1'b1;

        // Drain with a bounded wait
        begin
            int budget = 0;
            while (busy === 1'b1 && budget < 50) begin
                tick();
                budget++;
            end
            check("drain_idle", 32'(busy), 32'd0);
        end
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
